// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: datapath defaults and ALU opcodes.
package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_AW   = $clog2(NREG_DEF);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 2-read/1-write integer register file; register 0 is hardwired to zero.
module alu_issue_stage_regfile
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage: regfile read with writeback bypass, scoreboard hazard
// stall, and a registered operand/control slot presented to the ALU.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [3:0]      in_alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [3:0]      alu_ctrl,
  output logic [AW-1:0]   out_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  // Forward the in-flight writeback value when it targets this source.
  function automatic logic [XLEN-1:0] bypass(
    input logic [AW-1:0]   src,
    input logic [XLEN-1:0] rf_val,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    if (we && wa == src && src != '0) return wd;
    return rf_val;
  endfunction

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] src1_p0, src2_p0;
  logic [NREG-1:0] busy, wb_hit, busy_eff;
  logic            hazard_p0, fire_p0;

  logic            vld_p1;
  logic [XLEN-1:0] op1_p1, op2_p1;
  logic [3:0]      ctrl_p1;
  logic [AW-1:0]   rd_p1;

  alu_issue_stage_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (in_rs1),
    .ra2 (in_rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_en),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // A register whose writeback lands this cycle no longer blocks issue.
  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_rd] = 1'b1;
  end

  assign busy_eff = busy & ~wb_hit;

  // p0: operand selection and hazard detection
  assign src1_p0 = bypass(in_rs1, rf_rd1, wb_en, wb_rd, wb_data);
  assign src2_p0 = in_use_imm ? in_imm : bypass(in_rs2, rf_rd2, wb_en, wb_rd, wb_data);

  assign hazard_p0 = in_valid &&
                     (busy_eff[in_rs1] ||
                      (!in_use_imm && busy_eff[in_rs2]) ||
                      (in_rd != '0 && busy_eff[in_rd]));

  assign in_ready = !hazard_p0 && (!vld_p1 || out_ready);
  assign fire_p0  = in_valid && in_ready;

  // Set after clear so a same-index issue and writeback leaves the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_en && wb_rd != '0) busy[wb_rd] <= 1'b0;
      if (fire_p0 && in_rd != '0) busy[in_rd] <= 1'b1;
    end
  end

  // p1: registered issue slot facing the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      op1_p1  <= '0;
      op2_p1  <= '0;
      ctrl_p1 <= '0;
      rd_p1   <= '0;
    end else if (fire_p0) begin
      vld_p1  <= 1'b1;
      op1_p1  <= src1_p0;
      op2_p1  <= src2_p0;
      ctrl_p1 <= in_alu_ctrl;
      rd_p1   <= in_rd;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign operand1  = op1_p1;
  assign operand2  = op2_p1;
  assign alu_ctrl  = ctrl_p1;
  assign out_rd    = rd_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, reset-in-stall sequence,
// and randomized traffic against an array-based reference model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [31:0]     in_imm;
  logic            in_use_imm;
  logic [3:0]      in_alu_ctrl;
  logic            out_valid, out_ready;
  logic [31:0]     operand1, operand2;
  logic [3:0]      alu_ctrl;
  logic [4:0]      out_rd;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;

  int total = 0;
  int bad   = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand1(operand1), .operand2(operand2), .alu_ctrl(alu_ctrl), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wbe; logic [4:0] wbr; logic [31:0] wbd;
    logic        v;   logic [4:0] r1, r2, rd; logic [31:0] imm; logic ui; logic [3:0] ctl;
    logic        ordy;
    logic        er;  logic eov; logic [31:0] e1, e2; logic [3:0] ec; logic [4:0] erd;
  } vec_t;

  function automatic vec_t mk(
    input logic wbe, input int wbr, input logic [31:0] wbd,
    input logic v, input int r1, input int r2, input int rd, input logic [31:0] imm,
    input logic ui, input int ctl, input logic ordy,
    input logic er, input logic eov, input logic [31:0] e1, input logic [31:0] e2,
    input int ec, input int erd);
    vec_t t;
    t.wbe = wbe; t.wbr = 5'(wbr); t.wbd = wbd;
    t.v = v; t.r1 = 5'(r1); t.r2 = 5'(r2); t.rd = 5'(rd); t.imm = imm; t.ui = ui;
    t.ctl = 4'(ctl); t.ordy = ordy;
    t.er = er; t.eov = eov; t.e1 = e1; t.e2 = e2; t.ec = 4'(ec); t.erd = 5'(erd);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    wb_en = t.wbe; wb_rd = t.wbr; wb_data = t.wbd;
    in_valid = t.v; in_rs1 = t.r1; in_rs2 = t.r2; in_rd = t.rd;
    in_imm = t.imm; in_use_imm = t.ui; in_alu_ctrl = t.ctl; out_ready = t.ordy;
  endtask

  task automatic check_outs(input string tag, input logic eov, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [3:0] ec, input logic [4:0] erd);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({tag, ".operand1"}, operand1, e1);
    chk({tag, ".operand2"}, operand2, e2);
    chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(ec));
    chk({tag, ".out_rd"}, 32'(out_rd), 32'(erd));
  endtask

  // Reference model state
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  bit          m_ov;
  logic [31:0] m_op1, m_op2;
  logic [3:0]  m_ctl;
  logic [4:0]  m_rd;

  function automatic bit m_blocked(input logic [4:0] s);
    return m_busy[s] && !(wb_en && wb_rd == s);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    if (s == 0) return 32'd0;
    if (wb_en && wb_rd == s) return wb_data;
    return m_reg[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
    m_ov = 0; m_op1 = 0; m_op2 = 0; m_ctl = 0; m_rd = 0;
  endtask

  vec_t tbl [16];
  vec_t idle;

  initial begin
    idle = mk(0,0,0, 0,0,0,0,0,0,0,1, 1,0,0,0,0,0);
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1 chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    //        wbe wbr wbd         v r1 r2 rd imm          ui ctl ordy  er eov e1  e2           ec erd
    tbl[0]  = mk(1, 1, 5,          0, 0, 0, 0, 0,           0, 0, 1,   1, 0, 0,  0,           0, 0);
    tbl[1]  = mk(1, 2, 7,          0, 0, 0, 0, 0,           0, 0, 1,   1, 0, 0,  0,           0, 0);
    tbl[2]  = mk(0, 0, 0,          1, 1, 2, 3, 0,           0, 0, 1,   1, 1, 5,  7,           0, 3);
    tbl[3]  = mk(0, 0, 0,          1, 3, 3, 4, 0,           0, 1, 1,   0, 0, 5,  7,           0, 3);
    tbl[4]  = mk(1, 3, 12,         1, 3, 3, 4, 0,           0, 1, 1,   1, 1, 12, 12,          1, 4);
    tbl[5]  = mk(0, 0, 0,          1, 0, 4, 6, 32'hFFFFFFFF,1, 4, 1,   1, 1, 0,  32'hFFFFFFFF,4, 6);
    tbl[6]  = mk(0, 0, 0,          1, 1, 2, 7, 0,           0, 0, 0,   0, 1, 0,  32'hFFFFFFFF,4, 6);
    tbl[7]  = mk(0, 0, 0,          1, 1, 2, 7, 0,           0, 0, 0,   0, 1, 0,  32'hFFFFFFFF,4, 6);
    tbl[8]  = mk(0, 0, 0,          1, 1, 2, 7, 0,           0, 0, 0,   0, 1, 0,  32'hFFFFFFFF,4, 6);
    tbl[9]  = mk(0, 0, 0,          1, 1, 2, 7, 0,           0, 0, 1,   1, 1, 5,  7,           0, 7);
    tbl[10] = mk(0, 0, 0,          1, 1, 1, 5, 0,           0, 0, 1,   1, 1, 5,  5,           0, 5);
    tbl[11] = mk(0, 0, 0,          1, 0, 0, 5, 0,           0, 2, 1,   0, 0, 5,  5,           0, 5);
    tbl[12] = mk(1, 5, 20,         1, 0, 0, 5, 0,           0, 2, 1,   1, 1, 0,  0,           2, 5);
    tbl[13] = mk(1, 0, 9,          1, 0, 0, 0, 0,           0, 3, 1,   1, 1, 0,  0,           3, 0);
    tbl[14] = mk(1, 5, 33,         1, 0, 5, 0, 0,           0, 9, 1,   1, 1, 0,  33,          9, 0);
    tbl[15] = mk(0, 0, 0,          1, 5, 1, 0, 0,           0, 5, 1,   1, 1, 33, 5,           5, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #1 chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].eov, tbl[i].e1, tbl[i].e2, tbl[i].ec, tbl[i].erd);
    end

    // Reset while a RAW stall is pending on r3.
    drive(mk(0,0,0, 1,1,2,3,0,0,ALU_ADD,1, 1,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(0,0,0, 1,3,1,8,0,0,ALU_OR,1, 1,0,0,0,0,0));
    #1 chk("rststall.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outs("rststall.after", 0, 0, 0, 0, 0);
    #1 chk("rststall.busy_cleared", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_outs("rststall.regs_zero", 1, 0, 0, ALU_OR, 8);

    // Randomized traffic against the reference model.
    drive(idle);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic exp_rdy;
      wb_en       = ($urandom_range(0, 1) == 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 7));
      in_imm      = $urandom;
      in_use_imm  = ($urandom_range(0, 2) == 0);
      in_alu_ctrl = 4'($urandom_range(0, 15));
      out_ready   = ($urandom_range(0, 3) != 0);
      exp_rdy = !(in_valid && (m_blocked(in_rs1) || (!in_use_imm && m_blocked(in_rs2)) ||
                               (in_rd != 0 && m_blocked(in_rd))))
                && (!m_ov || out_ready);
      #1 chk($sformatf("rand%0d.in_ready", c), 32'(in_ready), 32'(exp_rdy));
      if (in_valid && exp_rdy) begin
        m_op1 = m_read(in_rs1);
        m_op2 = in_use_imm ? in_imm : m_read(in_rs2);
        m_ctl = in_alu_ctrl;
        m_rd  = in_rd;
        m_ov  = 1;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (wb_en && wb_rd != 0) begin
        m_reg[wb_rd]  = wb_data;
        m_busy[wb_rd] = 0;
      end
      if (in_valid && exp_rdy && in_rd != 0) m_busy[in_rd] = 1;
      @(posedge clk); #1;
      check_outs($sformatf("rand%0d", c), m_ov, m_op1, m_op2, m_ctl, m_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
